// File: rtl/pipeline_stall_flush_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipeline_stall_flush_ctrl_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] X0 = 5'd0;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_FLUSH    = 2'd3
  } state_t;

  // One ClockEnable per pipeline register, PC first.
  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } stage_en_t;

  localparam stage_en_t EN_NONE     = 5'b00000;
  localparam stage_en_t EN_ALL      = 5'b11111;
  localparam stage_en_t EN_FLUSH    = 5'b00011;
  localparam stage_en_t EN_LOAD_USE = 5'b00111;

endpackage

// File: rtl/pipeline_stall_flush_ctrl_hazard.sv
// Load-use hazard compare between the EX-stage load and the ID-stage sources.
module hazard_detect_unit
  import pipeline_stall_flush_ctrl_pkg::*;
(
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  output logic                  load_use_c
);

  // x0 is hardwired to zero, so a load into it never creates a dependency.
  assign load_use_c = ex_memread && (ex_rd != X0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/pipeline_stall_flush_ctrl.sv
// Stall/flush control for the IF/ID, ID/EX, EX/MEM, MEM/WB registers and the PC.
module pipeline_stall_flush_ctrl
  import pipeline_stall_flush_ctrl_pkg::*;
#(
  parameter int unsigned CntBits       = 16,
  parameter int unsigned WaitBits      = 8,
  parameter int unsigned TimeoutCycles = 200
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Tick,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_memread,
  input  logic                  branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic                  id_ex_bubble,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic [CntBits-1:0]    stall_count,
  output logic                  mem_timeout
);

  state_t               state, state_nxt;
  logic [WaitBits-1:0]  wait_cnt, wait_cnt_nxt;
  logic                 timeout_nxt;
  logic                 flush_nxt;
  logic                 load_use;
  logic                 mem_stall;
  stage_en_t            en;

  hazard_detect_unit u_hazard (
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .load_use_c (load_use)
  );

  assign mem_stall = mem_req && !mem_ready;

  // Next-state, enables and bubble select.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = '0;
    timeout_nxt  = mem_timeout;
    en           = EN_NONE;
    id_ex_bubble = 1'b0;
    case (state)
      ST_INIT: state_nxt = ST_RUN;
      ST_RUN, ST_MEM_WAIT: begin
        if (state == ST_RUN && mem_stall) begin
          state_nxt    = ST_MEM_WAIT;
          wait_cnt_nxt = WaitBits'(1);
        end else if (state == ST_MEM_WAIT && !mem_ready) begin
          state_nxt    = ST_MEM_WAIT;
          wait_cnt_nxt = (wait_cnt == '1) ? wait_cnt : wait_cnt + WaitBits'(1);
          if (wait_cnt_nxt >= WaitBits'(TimeoutCycles)) timeout_nxt = 1'b1;
        end else if (branch_taken) begin
          en        = EN_ALL;
          state_nxt = ST_FLUSH;
        end else if (load_use) begin
          en           = EN_LOAD_USE;
          id_ex_bubble = 1'b1;
          state_nxt    = ST_RUN;
        end else begin
          en        = EN_ALL;
          state_nxt = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (mem_stall) begin
          state_nxt    = ST_MEM_WAIT;
          wait_cnt_nxt = WaitBits'(1);
        end else begin
          en        = EN_FLUSH;
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  assign flush_nxt = (state_nxt == ST_FLUSH);

  // Flushes come straight from flops so the register Reset pins never glitch.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state       <= ST_INIT;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      if_id_flush <= 1'b1;
      id_ex_flush <= 1'b1;
    end else if (Tick) begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      mem_timeout <= timeout_nxt;
      if_id_flush <= flush_nxt;
      id_ex_flush <= flush_nxt;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      stall_count <= '0;
    end else if (Tick && !en.pc && state != ST_INIT && stall_count != '1) begin
      stall_count <= stall_count + CntBits'(1);
    end
  end

  assign pc_en     = en.pc;
  assign if_id_en  = en.if_id;
  assign id_ex_en  = en.id_ex;
  assign ex_mem_en = en.ex_mem;
  assign mem_wb_en = en.mem_wb;

endmodule

// File: tb/tb_pipeline_stall_flush_ctrl.sv
// Scoreboard bench: stimulus pushes reference-model expectations, a monitor pops and compares.
module tb_pipeline_stall_flush_ctrl;

  logic       Clock = 1'b0;
  logic       Reset, Tick;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       ex_memread, branch_taken, mem_req, mem_ready;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic       id_ex_bubble, if_id_flush, id_ex_flush, mem_timeout;
  logic [15:0] stall_count;

  pipeline_stall_flush_ctrl #(.CntBits(16), .WaitBits(8), .TimeoutCycles(200)) dut (
    .Clock(Clock), .Reset(Reset), .Tick(Tick),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .stall_count(stall_count), .mem_timeout(mem_timeout)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [4:0]  en;
    logic        bubble;
    logic [1:0]  flush;
    logic [15:0] sc;
    logic        to;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: pipeline situation described by flags and a waited-cycle count.
  bit m_init = 1'b1;
  bit m_flush = 1'b0;
  int m_wait = 0;
  int m_sc = 0;
  bit m_to = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit rst_n, input bit tick, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input bit memread, input bit br, input bit mreq,
                      input bit mrdy);
    exp_t e;
    bit lu, stall, n_flush, n_to;
    int n_wait;
    @(posedge Clock);
    #1;
    Reset = rst_n; Tick = tick; id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd;
    ex_memread = memread; branch_taken = br; mem_req = mreq; mem_ready = mrdy;
    if (!rst_n) begin
      m_init = 1'b1; m_flush = 1'b0; m_wait = 0; m_sc = 0; m_to = 1'b0;
      e.en = '0; e.bubble = 1'b0; e.flush = 2'b11; e.sc = '0; e.to = 1'b0;
      exp_q.push_back(e);
      return;
    end
    lu = memread && rd != 0 && (rd == rs1 || rd == rs2);
    stall = mreq && !mrdy;
    e.flush = (m_init || m_flush) ? 2'b11 : 2'b00;
    e.sc = 16'(m_sc);
    e.to = m_to;
    e.bubble = 1'b0;
    n_flush = 1'b0; n_wait = 0; n_to = m_to;
    if (m_init) e.en = 5'b00000;
    else if (m_flush && stall) begin e.en = 5'b00000; n_wait = 1; end
    else if (m_flush) e.en = 5'b00011;
    else if (m_wait > 0 && !mrdy) begin
      e.en = 5'b00000;
      n_wait = (m_wait < 255) ? m_wait + 1 : 255;
      if (n_wait >= 200) n_to = 1'b1;
    end
    else if (m_wait == 0 && stall) begin e.en = 5'b00000; n_wait = 1; end
    else if (br) begin e.en = 5'b11111; n_flush = 1'b1; end
    else if (lu) begin e.en = 5'b00111; e.bubble = 1'b1; end
    else e.en = 5'b11111;
    exp_q.push_back(e);
    if (tick) begin
      if (!e.en[4] && !m_init && m_sc < 65535) m_sc++;
      m_init = 1'b0; m_flush = n_flush; m_wait = n_wait; m_to = n_to;
    end
  endtask

  task automatic idle(input bit rst_n, input bit tick);
    step(rst_n, tick, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: one expectation per cycle, checked mid-cycle away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clock);
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("enables", {27'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, {27'd0, e.en});
        chk("bubble", {31'd0, id_ex_bubble}, {31'd0, e.bubble});
        chk("flushes", {30'd0, if_id_flush, id_ex_flush}, {30'd0, e.flush});
        chk("stall_count", {16'd0, stall_count}, {16'd0, e.sc});
        chk("mem_timeout", {31'd0, mem_timeout}, {31'd0, e.to});
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1);
  end

  initial begin
    Reset = 1'b0; Tick = 1'b1; id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    ex_memread = 1'b0; branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b1;
    repeat (3) idle(1'b0, 1'b1);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b1);
    // load-use on rs2, then the dependency clears
    step(1'b1, 1'b1, 5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 5'd1, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
    // load into x0 never stalls
    step(1'b1, 1'b1, 5'd0, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    // memory wait, then resume
    repeat (5) step(1'b1, 1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1'b1, 1'b1);
    // long wait trips the sticky timeout, with a few Tick-low cycles inside
    repeat (100) step(1'b1, 1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (105) step(1'b1, 1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    // ready arrives together with a taken branch: branch must be honoured
    step(1'b1, 1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (3) idle(1'b1, 1'b1);
    // branch coinciding with load-use
    step(1'b1, 1'b1, 5'd4, 5'd2, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b1);
    // branch, then a memory stall during FLUSH
    step(1'b1, 1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) step(1'b1, 1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    // asynchronous reset in the middle of a memory wait
    step(1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b0, 1'b1);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b1);
    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      bit rst_n, tick, memread, br, mreq, mrdy;
      logic [4:0] rs1, rs2, rd;
      rst_n   = ($urandom_range(0, 199) != 0);
      tick    = ($urandom_range(0, 99) < 85);
      rs1     = 5'($urandom_range(0, 3));
      rs2     = 5'($urandom_range(0, 3));
      rd      = 5'($urandom_range(0, 3));
      memread = ($urandom_range(0, 99) < 40);
      br      = ($urandom_range(0, 99) < 12);
      mreq    = ($urandom_range(0, 99) < 30);
      mrdy    = ($urandom_range(0, 99) < 50);
      step(rst_n, tick, rs1, rs2, rd, memread, br, mreq, mrdy);
    end
    repeat (2) @(negedge Clock);
    chk("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
